// File: rtl/pagerank_iter_engine_if.sv
// Control, configuration and read-back bus of the PageRank iteration engine.
//   start                  run request
//   adjacency / weights    graph and per-source 1/outdeg weights
//   max_iter / eps         iteration cap and convergence threshold
//   busy / done            run status; converged / iter_count describe the last run
//   rd_addr / rd_data      registered read port onto the committed value buffer
// slave  : engine side; master : requester side.
interface pagerank_iter_engine_if #(
    parameter int unsigned N      = 16,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ITER_W = 8
);
    localparam int unsigned AW = $clog2(N);

    logic                  start;
    logic [N*N-1:0]        adjacency;
    logic [N*WIDTH-1:0]    weights;
    logic [ITER_W-1:0]     max_iter;
    logic [WIDTH-1:0]      eps;
    logic                  busy;
    logic                  done;
    logic                  converged;
    logic [ITER_W-1:0]     iter_count;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;

    modport slave (
        input  start, adjacency, weights, max_iter, eps, rd_addr,
        output busy, done, converged, iter_count, rd_data
    );

    modport master (
        output start, adjacency, weights, max_iter, eps, rd_addr,
        input  busy, done, converged, iter_count, rd_data
    );
endinterface

// File: rtl/pagerank_iter_engine.sv
// Iterative (Jacobi) PageRank engine, one multiply-accumulate per clock.
// Values are unsigned Q0.WIDTH. Stops when max |new-old| <= eps or when the
// iteration cap is reached.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any run and restores 1/N values
//   bus    pagerank_iter_engine_if.slave (start/busy/done handshake,
//          configuration, run status and registered read port)
module pagerank_iter_engine #(
    parameter int unsigned    N      = 16,
    parameter int unsigned    WIDTH  = 16,
    parameter logic [WIDTH-1:0] D    = WIDTH'('h2666),
    parameter int unsigned    ITER_W = 8
) (
    input  logic clk,
    input  logic reset,
    pagerank_iter_engine_if.slave bus
);
    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned ACC_W = WIDTH + AW;
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [WIDTH-1:0] INIT = WIDTH'((64'(1) << WIDTH) / 64'(N));
    localparam logic [WIDTH-1:0] DN   = WIDTH'(64'(D) / 64'(N));
    localparam logic [WIDTH-1:0] DB   = WIDTH'((64'(1) << WIDTH) - 64'(D));
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_finish;

    logic [N*N-1:0]      r_adj;
    logic [WIDTH-1:0]    r_wdb   [N];
    logic [WIDTH-1:0]    r_cur   [N];
    logic [WIDTH-1:0]    r_nxt   [N];
    logic [ITER_W-1:0]   r_max_iter;
    logic [WIDTH-1:0]    r_eps;
    logic [AW-1:0]       r_p;
    logic [AW-1:0]       r_k;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_maxdiff;
    logic [ITER_W-1:0]   r_iter;
    logic                r_busy;
    logic                r_done;
    logic                r_conv;
    logic [WIDTH-1:0]    r_rd_data;

    logic [WIDTH-1:0]    w_wdb_in [N];
    logic [PW-1:0]       w_prod_full;
    logic [WIDTH-1:0]    w_prod;
    logic                w_edge;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [ACC_W-1:0]    w_cur_p;
    logic [ACC_W-1:0]    w_diff;
    logic [WIDTH-1:0]    w_sat;
    logic [ITER_W-1:0]   w_iter_inc;
    logic [ITER_W-1:0]   w_cap;
    logic                w_conv_hit;
    logic                w_cap_hit;

    // Damped weights DB*w[k], computed straight from the port at start accept
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_wdb_in[k] = WIDTH'((PW'(DB) * PW'(bus.weights[k*WIDTH +: WIDTH])) >> WIDTH);
        end
    end

    // MAC datapath: {p,k} indexes bit p*N+k since N is a power of two
    always_comb begin
        w_prod_full = PW'(r_wdb[r_k]) * PW'(r_cur[r_k]);
        w_prod      = WIDTH'(w_prod_full >> WIDTH);
        w_edge      = r_adj[{r_p, r_k}] && (r_p != r_k);
        w_acc_sum   = r_acc + ACC_W'(w_prod);
        w_cur_p     = ACC_W'(r_cur[r_p]);
        w_diff      = (r_acc >= w_cur_p) ? (r_acc - w_cur_p) : (w_cur_p - r_acc);
        w_sat       = (r_acc > ACC_W'(MAXV)) ? MAXV : WIDTH'(r_acc);
        w_iter_inc  = r_iter + ITER_W'(1);
        w_cap       = (r_max_iter == '0) ? ITER_W'(1) : r_max_iter;
        w_conv_hit  = (r_maxdiff <= ACC_W'(r_eps));
        w_cap_hit   = (w_iter_inc == w_cap);
    end

    // Next-state logic and run start/finish strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_accept    = 1'b1;
                end
            end
            S_LOAD:  w_state_nxt = S_ACCUM;
            S_ACCUM: begin
                if (r_k == AW'(N - 1)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: w_state_nxt = (r_p == AW'(N - 1)) ? S_CHECK : S_ACCUM;
            S_CHECK: begin
                // Convergence takes priority over the cap in the same iteration
                if (w_conv_hit || w_cap_hit) begin
                    w_state_nxt = S_DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, buffers and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adj      <= '0;
            r_max_iter <= '0;
            r_eps      <= '0;
            r_p        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_maxdiff  <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_rd_data  <= '0;
            for (int i = 0; i < N; i++) begin
                r_wdb[i] <= '0;
                r_cur[i] <= INIT;
                r_nxt[i] <= INIT;
            end
        end else begin
            r_rd_data <= r_cur[bus.rd_addr];

            if (w_accept) begin
                r_adj      <= bus.adjacency;
                r_max_iter <= bus.max_iter;
                r_eps      <= bus.eps;
                r_p        <= '0;
                r_k        <= '0;
                r_acc      <= ACC_W'(DN);
                r_maxdiff  <= '0;
                r_iter     <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_conv     <= 1'b0;
                for (int i = 0; i < N; i++) begin
                    r_wdb[i] <= w_wdb_in[i];
                    r_cur[i] <= INIT;
                end
            end

            case (r_state)
                S_ACCUM: begin
                    if (w_edge) begin
                        r_acc <= w_acc_sum;
                    end
                    r_k <= r_k + AW'(1);
                end
                S_WRITE: begin
                    r_nxt[r_p] <= w_sat;
                    if (w_diff > r_maxdiff) begin
                        r_maxdiff <= w_diff;
                    end
                    r_p   <= r_p + AW'(1);
                    r_acc <= ACC_W'(DN);
                end
                S_CHECK: begin
                    r_iter    <= w_iter_inc;
                    r_maxdiff <= '0;
                    r_p       <= '0;
                    r_acc     <= ACC_W'(DN);
                    for (int i = 0; i < N; i++) begin
                        r_cur[i] <= r_nxt[i];
                    end
                    if (w_finish) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_conv <= w_conv_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.converged  = r_conv;
    assign bus.iter_count = r_iter;
    assign bus.rd_data    = r_rd_data;

endmodule

// File: tb/tb_pagerank_iter_engine.sv
// Scoreboard bench for pagerank_iter_engine (N=16, WIDTH=16).
// Stimulus pushes expected read results and expected end-of-run status into
// queues; a monitor pops and compares whenever a read response or a done
// rising edge appears.
module tb_pagerank_iter_engine;
    localparam int unsigned N      = 16;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ITER_W = 8;
    localparam int unsigned AW     = $clog2(N);
    localparam int          ITER_CYC = N * (N + 1) + 1;

    typedef struct {
        string        nm;
        logic [15:0]  rd;
        logic         busy;
        logic         done;
    } rd_exp_t;

    typedef struct {
        string        nm;
        int           edge_at;
        logic         conv;
        logic [7:0]   iters;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pagerank_iter_engine_if #(.N(N), .WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

    pagerank_iter_engine #(
        .N(N), .WIDTH(WIDTH), .D(16'h2666), .ITER_W(ITER_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_cnt = 0;
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;
    logic done_prev = 1'b0;

    always @(posedge clk) begin
        edge_cnt++;
        rd_req_d <= rd_req;
    end

    // Monitor: read responses one cycle after the request, done on its rising edge
    always @(negedge clk) begin
        rd_exp_t   re;
        done_exp_t de;
        if (rd_req_d) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: rd_data=%h with no expectation queued", bus.rd_data);
            end else begin
                re = rd_q.pop_front();
                if (bus.rd_data !== re.rd || bus.busy !== re.busy || bus.done !== re.done) begin
                    n_err++;
                    $display("FAIL %s: rd_data=%h busy=%b done=%b, required rd_data=%h busy=%b done=%b",
                             re.nm, bus.rd_data, bus.busy, bus.done, re.rd, re.busy, re.done);
                end
            end
        end
        if (bus.done === 1'b1 && done_prev !== 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: done rose at edge %0d with no run expected", edge_cnt);
            end else begin
                de = done_q.pop_front();
                if (edge_cnt != de.edge_at || bus.converged !== de.conv ||
                    bus.iter_count !== de.iters || bus.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s: done_edge=%0d conv=%b iters=%0d busy=%b, required done_edge=%0d conv=%b iters=%0d busy=0",
                             de.nm, edge_cnt, bus.converged, bus.iter_count, bus.busy,
                             de.edge_at, de.conv, de.iters);
                end
            end
        end
        done_prev = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) tick();
    endtask

    task automatic rd_check(input int addr, input logic [15:0] v, input logic b,
                            input logic d, input string nm);
        rd_exp_t x;
        x.nm = nm; x.rd = v; x.busy = b; x.done = d;
        bus.rd_addr = AW'(addr);
        rd_req = 1'b1;
        rd_q.push_back(x);
        tick();
        rd_req = 1'b0;
    endtask

    // Issues a start; returns the start-accept edge number
    task automatic start_run(input logic [N*N-1:0] adj, input logic [N*WIDTH-1:0] w,
                             input int mi, input int ep, input bit expect_done,
                             input int lat, input logic conv, input int iters,
                             input string nm, output int t0);
        done_exp_t x;
        bus.adjacency = adj;
        bus.weights   = w;
        bus.max_iter  = ITER_W'(mi);
        bus.eps       = WIDTH'(ep);
        bus.start     = 1'b1;
        if (expect_done) begin
            x.nm = nm; x.edge_at = edge_cnt + 1 + lat; x.conv = conv; x.iters = 8'(iters);
            done_q.push_back(x);
        end
        tick();
        t0 = edge_cnt;
        bus.start = 1'b0;
        tick();
        // Inputs changed after the LOAD cycle must not disturb the run
        bus.adjacency = '1;
        bus.weights   = '1;
        bus.max_iter  = ITER_W'(2);
        bus.eps       = '1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i = 0;
        while (bus.done !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required done=1", nm, bus.done, budget);
            if (done_q.size() != 0) void'(done_q.pop_front());
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*N-1:0]     adj;
        logic [N*WIDTH-1:0] w;
        int                 t0;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.adjacency = '0;
        bus.weights   = '0;
        bus.max_iter  = '0;
        bus.eps       = '0;
        bus.rd_addr   = '0;
        repeat (3) tick();
        reset = 1'b0;

        // T1: reset state
        for (int a = 0; a < N; a++) rd_check(a, 16'h1000, 1'b0, 1'b0, "t1_reset_val");

        // T2: no edges, converges after iteration 2
        adj = '0; w = '0;
        start_run(adj, w, 8, 0, 1'b1, 1 + 2 * ITER_CYC, 1'b1, 2, "t2_done", t0);
        wait_until(t0 + 299);
        rd_check(5, 16'h0266, 1'b1, 1'b0, "t2_mid_node5");
        wait_done(2000, "t2");
        rd_check(0, 16'h0266, 1'b0, 1'b1, "t2_node0");
        rd_check(15, 16'h0266, 1'b0, 1'b1, "t2_node15");

        // T3: single edge 1->0
        adj = '0; adj[1] = 1'b1;
        w = '0; w[1*WIDTH +: WIDTH] = 16'hFFFF;
        start_run(adj, w, 8, 0, 1'b1, 1 + 3 * ITER_CYC, 1'b1, 3, "t3_done", t0);
        wait_until(t0 + 399);
        rd_check(0, 16'h0FFF, 1'b1, 1'b0, "t3_iter1_node0");
        wait_until(t0 + 649);
        rd_check(0, 16'h046F, 1'b1, 1'b0, "t3_iter2_node0");
        wait_done(2000, "t3");
        rd_check(0, 16'h046F, 1'b0, 1'b1, "t3_node0");
        rd_check(1, 16'h0266, 1'b0, 1'b1, "t3_node1");
        rd_check(2, 16'h0266, 1'b0, 1'b1, "t3_node2");

        // T4: self-loop ignored, capped at one iteration
        adj = '0; adj[0] = 1'b1;
        w = '0; w[0 +: WIDTH] = 16'hFFFF;
        start_run(adj, w, 1, 0, 1'b1, 1 + ITER_CYC, 1'b0, 1, "t4_done", t0);
        wait_done(2000, "t4");
        rd_check(0, 16'h0266, 1'b0, 1'b1, "t4_node0");

        // T5: cap with a second start while busy
        adj = '0; adj[1] = 1'b1;
        w = '0; w[1*WIDTH +: WIDTH] = 16'hFFFF;
        start_run(adj, w, 1, 0, 1'b1, 1 + ITER_CYC, 1'b0, 1, "t5_done", t0);
        wait_until(t0 + 49);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(2000, "t5");
        rd_check(0, 16'h0FFF, 1'b0, 1'b1, "t5_node0");
        rd_check(1, 16'h0266, 1'b0, 1'b1, "t5_node1");

        // T7: max_iter = 0 behaves as a cap of one
        adj = '0; w = '0;
        start_run(adj, w, 0, 0, 1'b1, 1 + ITER_CYC, 1'b0, 1, "t7_cap0_done", t0);
        wait_done(2000, "t7");

        // T8: maxdiff exactly equal to eps converges and beats the cap
        adj = '0; w = '0;
        start_run(adj, w, 1, 16'h0D9A, 1'b1, 1 + ITER_CYC, 1'b1, 1, "t8_eps_edge_done", t0);
        wait_done(2000, "t8");
        rd_check(3, 16'h0266, 1'b0, 1'b1, "t8_node3");

        // T6: reset mid-run aborts and restores 1/N
        adj = '0; adj[1] = 1'b1;
        w = '0; w[1*WIDTH +: WIDTH] = 16'hFFFF;
        start_run(adj, w, 8, 0, 1'b0, 0, 1'b0, 0, "t6", t0);
        wait_until(t0 + 99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < N; a++) rd_check(a, 16'h1000, 1'b0, 1'b0, "t6_abort_val");

        repeat (5) tick();
        if (rd_q.size() != 0 || done_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d reads and %0d runs still pending, required 0 and 0",
                     rd_q.size(), done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
